// File: rtl/sn76489_psg_stereo.sv
// SN76489-style PSG with Game-Gear stereo panning: write decoder, tone/noise
// generators, log attenuation and registered left/right PCM mix.

module sn76489_tone_ch (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_tick,
    input  logic [9:0] i_freq,
    output logic       o_out
);
    logic [9:0] r_cnt;
    logic       r_tog;
    logic       w_pcm;

    // Period 0/1 is the PCM trick: the output sits high and att drives the level.
    assign w_pcm = (i_freq <= 10'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 10'd0;
            r_tog <= 1'b0;
        end else if (i_tick) begin
            if (r_cnt <= 10'd1) begin
                r_cnt <= i_freq;
                r_tog <= w_pcm ? 1'b1 : ~r_tog;
            end else begin
                r_cnt <= r_cnt - 10'd1;
            end
        end
    end

    assign o_out = r_tog | w_pcm;
endmodule

module sn76489_psg_stereo #(
    parameter int NUM_TONES    = 3,
    parameter int CLK_DIV      = 16,
    parameter int LFSR_WIDTH   = 16,
    parameter int NOISE_TAP    = 3,
    parameter int READY_CYCLES = 32,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           d,
    input  logic                 nWE,
    input  logic                 nCE,
    input  logic                 nStereoCE,
    output logic                 ready,
    output logic [OUT_WIDTH-1:0] aOutL,
    output logic [OUT_WIDTH-1:0] aOutR
);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam int BCW  = $clog2(READY_CYCLES) + 1;
    localparam logic [LFSR_WIDTH-1:0] SEED = {1'b1, {(LFSR_WIDTH-1){1'b0}}};

    logic                  r_psgIdle, r_stIdle;
    logic                  r_ready;
    logic [BCW-1:0]        r_busyCnt;
    logic [1:0]            r_ch;
    logic                  r_type;
    logic [2:0]            r_noiseCtl;
    logic                  r_reseed;
    logic [3:0]            r_att [4];
    logic [9:0]            r_freq [NUM_TONES];
    logic [7:0]            r_stereo;
    logic [DIVW-1:0]       r_div;
    logic [9:0]            r_ncnt;
    logic                  r_nflip;
    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [OUT_WIDTH-1:0]  r_outL, r_outR;

    logic       w_psgStb, w_stStb, w_psgAcc, w_stAcc;
    logic [1:0] w_ch;
    logic       w_type;
    logic       w_tick;
    logic [9:0] w_nReload;
    logic       w_fb;
    logic [3:0] w_chOut;
    logic [14:0] w_sumL, w_sumR;

    // Writes are edge-triggered: a strobe held low is accepted only once.
    assign w_psgStb = ~(nCE | nWE);
    assign w_stStb  = ~(nStereoCE | nWE);
    assign w_psgAcc = w_psgStb & r_psgIdle & r_ready;
    assign w_stAcc  = w_stStb & r_stIdle;

    assign w_ch   = d[7] ? d[6:5] : r_ch;
    assign w_type = d[7] ? d[4]   : r_type;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_psgIdle <= 1'b1;
            r_stIdle  <= 1'b1;
            r_ready   <= 1'b1;
            r_busyCnt <= '0;
            r_stereo  <= 8'hFF;
        end else begin
            r_psgIdle <= ~w_psgStb;
            r_stIdle  <= ~w_stStb;
            if (w_stAcc)
                r_stereo <= d;
            if (w_psgAcc) begin
                r_ready   <= 1'b0;
                r_busyCnt <= BCW'(READY_CYCLES - 1);
            end else if (!r_ready) begin
                if (r_busyCnt == '0)
                    r_ready <= 1'b1;
                else
                    r_busyCnt <= r_busyCnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ch       <= 2'd0;
            r_type     <= 1'b0;
            r_noiseCtl <= 3'd0;
            r_reseed   <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_att[i] <= 4'hF;
            for (int i = 0; i < NUM_TONES; i++)
                r_freq[i] <= 10'd0;
        end else begin
            r_reseed <= 1'b0;
            if (w_psgAcc) begin
                if (d[7]) begin
                    r_ch   <= d[6:5];
                    r_type <= d[4];
                end
                if (w_type) begin
                    r_att[w_ch] <= d[3:0];
                end else if (w_ch == 2'd3) begin
                    r_noiseCtl <= d[2:0];
                    r_reseed   <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_TONES; i++) begin
                        if (w_ch == 2'(i)) begin
                            if (d[7])
                                r_freq[i][3:0] <= d[3:0];
                            else
                                r_freq[i][9:4] <= d[5:0];
                        end
                    end
                end
            end
        end
    end

    assign w_tick = (r_div == DIVW'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)
            r_div <= '0;
        else
            r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    genvar g;
    for (g = 0; g < 3; g++) begin : g_ch
        if (g < NUM_TONES) begin : g_tone
            sn76489_tone_ch u_tone (
                .clock  (clock),
                .reset  (reset),
                .i_tick (w_tick),
                .i_freq (r_freq[g]),
                .o_out  (w_chOut[g])
            );
        end else begin : g_off
            assign w_chOut[g] = 1'b0;
        end
    end

    always_comb begin
        w_nReload = r_freq[NUM_TONES-1];
        case (r_noiseCtl[1:0])
            2'd0:    w_nReload = 10'd16;
            2'd1:    w_nReload = 10'd32;
            2'd2:    w_nReload = 10'd64;
            default: w_nReload = r_freq[NUM_TONES-1];
        endcase
    end

    assign w_fb = r_noiseCtl[2] ? (r_lfsr[0] ^ r_lfsr[NOISE_TAP]) : r_lfsr[0];

    // The LFSR steps once per full flip period (on its rising half).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ncnt  <= 10'd0;
            r_nflip <= 1'b0;
            r_lfsr  <= SEED;
        end else begin
            if (r_reseed)
                r_lfsr <= SEED;
            else if (w_tick && r_ncnt <= 10'd1 && !r_nflip)
                r_lfsr <= {w_fb, r_lfsr[LFSR_WIDTH-1:1]};
            if (w_tick) begin
                if (r_ncnt <= 10'd1) begin
                    r_ncnt  <= w_nReload;
                    r_nflip <= ~r_nflip;
                end else begin
                    r_ncnt <= r_ncnt - 10'd1;
                end
            end
        end
    end

    assign w_chOut[3] = r_lfsr[0];

    function automatic logic [12:0] att_lvl(input logic [3:0] a);
        case (a)
            4'd0:    att_lvl = 13'd8191;
            4'd1:    att_lvl = 13'd6506;
            4'd2:    att_lvl = 13'd5168;
            4'd3:    att_lvl = 13'd4105;
            4'd4:    att_lvl = 13'd3261;
            4'd5:    att_lvl = 13'd2590;
            4'd6:    att_lvl = 13'd2057;
            4'd7:    att_lvl = 13'd1634;
            4'd8:    att_lvl = 13'd1298;
            4'd9:    att_lvl = 13'd1031;
            4'd10:   att_lvl = 13'd819;
            4'd11:   att_lvl = 13'd650;
            4'd12:   att_lvl = 13'd517;
            4'd13:   att_lvl = 13'd410;
            4'd14:   att_lvl = 13'd326;
            default: att_lvl = 13'd0;
        endcase
    endfunction

    always_comb begin
        logic [12:0] lvl;
        w_sumL = 15'd0;
        w_sumR = 15'd0;
        lvl    = 13'd0;
        for (int ch = 0; ch < 4; ch++) begin
            lvl = w_chOut[ch] ? att_lvl(r_att[ch]) : 13'd0;
            if (r_stereo[4+ch])
                w_sumL = w_sumL + 15'(lvl);
            if (r_stereo[ch])
                w_sumR = w_sumR + 15'(lvl);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_outL <= '0;
            r_outR <= '0;
        end else begin
            r_outL <= OUT_WIDTH'(w_sumL);
            r_outR <= OUT_WIDTH'(w_sumR);
        end
    end

    assign ready = r_ready;
    assign aOutL = r_outL;
    assign aOutR = r_outR;
endmodule

// File: tb/tb_sn76489_psg_stereo.sv
// Scoreboard bench for sn76489_psg_stereo: expected mix changes are queued by
// the stimulus and popped by a monitor each time the DUT output moves.

module tb_sn76489_psg_stereo;
    localparam int READY_CYCLES = 32;
    localparam int HALF_TONE    = 254 * 16;
    localparam int SHIFT_CLKS   = 2 * 16 * 16;

    typedef struct {
        int l;
        int r;
        int ivl;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  d;
    logic        nWE, nCE, nStereoCE;
    logic        ready;
    logic [15:0] aOutL, aOutR;

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    exp_t q[$];

    // Reference state for the PCM-mode stereo phases.
    int   tab [16] = '{8191, 6506, 5168, 4105, 3261, 2590, 2057, 1634,
                       1298, 1031, 819, 650, 517, 410, 326, 0};
    int   m_att [4];
    logic [7:0] m_st;
    int   cur_l, cur_r;

    sn76489_psg_stereo dut (
        .clock     (clock),
        .reset     (reset),
        .d         (d),
        .nWE       (nWE),
        .nCE       (nCE),
        .nStereoCE (nStereoCE),
        .ready     (ready),
        .aOutL     (aOutL),
        .aOutR     (aOutR)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int l, input int r, input int ivl);
        exp_t e;
        e.l = l; e.r = r; e.ivl = ivl;
        q.push_back(e);
    endtask

    // Mix with every tone channel in PCM mode (out=1) and noise silenced.
    function automatic int calc(input bit right);
        int s = 0;
        for (int ch = 0; ch < 3; ch++)
            if (m_st[(right ? 0 : 4) + ch]) s += tab[m_att[ch]];
        return s;
    endfunction

    task automatic upd();
        int nl, nr;
        nl = calc(1'b0);
        nr = calc(1'b1);
        if (nl != cur_l || nr != cur_r) push(nl, nr, 0);
        cur_l = nl;
        cur_r = nr;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (q.size() > 0) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout: %0d expected changes never seen, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic psg_wr(input logic [7:0] b, input bit glitch, input bit st);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("ready_wait", 0, 1);
        d = b; nCE = 1'b0; nWE = 1'b0;
        if (st) nStereoCE = 1'b0;
        @(negedge clock);
        nCE = 1'b1; nWE = 1'b1; nStereoCE = 1'b1;
        n = 0;
        while (ready === 1'b0 && n < 100) begin
            if (glitch && n == 10) begin
                d = 8'h90; nCE = 1'b0; nWE = 1'b0;
            end else begin
                nCE = 1'b1; nWE = 1'b1;
            end
            n++;
            @(negedge clock);
        end
        nCE = 1'b1; nWE = 1'b1;
        chk("busy_len", n, READY_CYCLES);
    endtask

    task automatic st_wr(input logic [7:0] b);
        d = b; nStereoCE = 1'b0; nWE = 1'b0;
        @(negedge clock);
        nStereoCE = 1'b1; nWE = 1'b1;
    endtask

    initial begin : monitor
        int   pl = 0, pr = 0, last = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (int'(aOutL) != pl || int'(aOutR) != pr) begin
                if (q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_change: got L=%0d R=%0d, expected no change (cycle %0d)",
                             aOutL, aOutR, cyc);
                end else begin
                    e = q.pop_front();
                    chk("mix_L", int'(aOutL), e.l);
                    chk("mix_R", int'(aOutR), e.r);
                    if (e.ivl != 0) chk("change_interval", cyc - last, e.ivl);
                end
                pl = int'(aOutL);
                pr = int'(aOutR);
                last = cyc;
            end
        end
    end

    initial begin : stim
        exp_t nz[$];
        logic [15:0] s;
        int   lastk, lastv, hold_l, hold_r, op;
        logic [31:0] v;

        reset = 1'b1; d = 8'h00; nWE = 1'b1; nCE = 1'b1; nStereoCE = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", int'(ready), 1);
        chk("reset_L", int'(aOutL), 0);
        chk("reset_R", int'(aOutR), 0);

        // All channels silent; a strobe while busy must be ignored.
        psg_wr(8'h9F, 1'b1, 1'b0);
        psg_wr(8'hBF, 1'b0, 1'b0);
        psg_wr(8'hDF, 1'b0, 1'b0);
        psg_wr(8'hFF, 1'b0, 1'b0);
        repeat (300) @(negedge clock);

        // ch0 square wave at freq 0x0FE; the first change is always 0 -> 8191.
        psg_wr(8'h8E, 1'b0, 1'b0);
        psg_wr(8'h0F, 1'b0, 1'b0);
        push(8191, 8191, 0);
        push(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            push(8191, 8191, HALF_TONE);
            push(0, 0, HALF_TONE);
        end
        psg_wr(8'h90, 1'b0, 1'b0);
        drain(32000);
        psg_wr(8'h9F, 1'b0, 1'b0);
        psg_wr(8'h80, 1'b0, 1'b0);
        psg_wr(8'h00, 1'b0, 1'b0);

        // ch1 PCM mode at att 4.
        psg_wr(8'hA1, 1'b0, 1'b0);
        push(3261, 3261, 0);
        psg_wr(8'hB4, 1'b0, 1'b0);
        repeat (1000) @(negedge clock);
        drain(10);
        push(0, 0, 0);
        psg_wr(8'hBF, 1'b0, 1'b0);
        drain(100);

        // White noise from seed 0x8000, taps 0 and 3, one shift per 512 clocks.
        s = 16'h8000; lastk = -1; lastv = 0;
        for (int k = 1; k <= 32; k++) begin
            s = {s[0] ^ s[3], s[15:1]};
            if (int'(s[0]) != lastv) begin
                exp_t e;
                e.l = s[0] ? 8191 : 0;
                e.r = e.l;
                e.ivl = (lastk < 0) ? 0 : (k - lastk) * SHIFT_CLKS;
                nz.push_back(e);
                q.push_back(e);
                lastk = k;
                lastv = int'(s[0]);
            end
        end
        psg_wr(8'hE4, 1'b0, 1'b0);
        psg_wr(8'hF0, 1'b0, 1'b0);
        drain(20000);
        if (lastv != 0) push(0, 0, 0);
        psg_wr(8'hE4, 1'b0, 1'b0);
        q.push_back(nz[0]);
        q.push_back(nz[1]);
        drain(10000);
        psg_wr(8'hFF, 1'b0, 1'b0);
        drain(100);

        // Stereo panning with ch0/ch2 in PCM mode.
        for (int i = 0; i < 4; i++) m_att[i] = 15;
        m_st = 8'hFF; cur_l = 0; cur_r = 0;
        m_att[0] = 0; upd(); psg_wr(8'h90, 1'b0, 1'b0);
        m_att[2] = 0; upd(); psg_wr(8'hD0, 1'b0, 1'b0);
        m_st = 8'h40; upd(); st_wr(8'h40); repeat (3) @(negedge clock);
        m_st = 8'h41; upd(); st_wr(8'h41); repeat (3) @(negedge clock);
        m_st = 8'h00; upd(); st_wr(8'h00); repeat (3) @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 2);
            v  = $urandom;
            case (op)
                0: begin m_att[0] = int'(v[3:0]); upd(); psg_wr({4'h9, v[3:0]}, 1'b0, 1'b0); end
                1: begin m_att[2] = int'(v[3:0]); upd(); psg_wr({4'hD, v[3:0]}, 1'b0, 1'b0); end
                default: begin m_st = v[7:0]; upd(); st_wr(v[7:0]); repeat (3) @(negedge clock); end
            endcase
        end
        // One byte on both strobes: ch0 att 1 and stereo 0x91 together.
        m_att[0] = 1; m_st = 8'h91; upd();
        psg_wr(8'h91, 1'b0, 1'b1);
        drain(100);
        hold_l = cur_l; hold_r = cur_r;
        m_st = 8'h00; upd();
        st_wr(8'h00);
        chk("stereo_hold_L", int'(aOutL), hold_l);
        chk("stereo_hold_R", int'(aOutR), hold_r);
        @(negedge clock);
        chk("stereo_off_L", int'(aOutL), 0);
        chk("stereo_off_R", int'(aOutR), 0);
        drain(100);

        // Reset while busy with tones sounding.
        m_st = 8'h0F; upd(); st_wr(8'h0F); repeat (3) @(negedge clock);
        m_att[1] = 0; upd();
        d = 8'hB0; nCE = 1'b0; nWE = 1'b0;
        @(negedge clock);
        nCE = 1'b1; nWE = 1'b1;
        repeat (5) @(negedge clock);
        chk("busy_mid", int'(ready), 0);
        push(0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_busy_ready", int'(ready), 1);
        chk("rst_busy_L", int'(aOutL), 0);
        chk("rst_busy_R", int'(aOutR), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_att[i] = 15;
        m_st = 8'hFF; cur_l = 0; cur_r = 0;
        m_att[0] = 0; upd();
        psg_wr(8'h90, 1'b0, 1'b0);
        drain(200);
        repeat (50) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sn76489_psg_stereo.md
Name: sn76489_psg_stereo

Overview:
Parametrised next-generation PSG core for the 315-5124 emulator tree. Integrates the CPU write decoder, 1–3 square-tone channels, an LFSR noise channel, per-channel log attenuation, and a Game-Gear-style stereo panning register. Produces independent left/right unsigned PCM sums. Sits on the I/O bus beside the VDP and feeds the audio DAC/PWM stage.

Parameters:
NUM_TONES, 3, number of tone channels (1..3); the noise channel is always channel index 3.
CLK_DIV, 16, clock-enable divider ratio (>=2); one tick every CLK_DIV clocks.
LFSR_WIDTH, 16, noise shift-register width (15 or 16).
NOISE_TAP, 3, second tap for white-noise feedback (1..LFSR_WIDTH-1).
READY_CYCLES, 32, clocks that ready stays low after an accepted write.
OUT_WIDTH, 16, output width (>=15).

Ports:
clock  in  1  system clock (3579545 Hz NTSC / 3546893 Hz PAL)
reset  in  1  synchronous, active-high
d  in  8  CPU write data
nWE  in  1  write strobe, active low
nCE  in  1  PSG chip enable, active low
nStereoCE  in  1  stereo register enable, active low (qualified by nWE)
ready  out  1  high when the next write can be accepted
aOutL  out  OUT_WIDTH  left mix, unsigned
aOutR  out  OUT_WIDTH  right mix, unsigned

Behaviour:
- Reset values: freq[*]=0, att[*]=4'hF, noiseCtl=0, latched channel/type=0/tone, lfsr=1<<(LFSR_WIDTH-1), stereo=8'hFF, divider=0, tone/noise out bits=0, ready=1, aOutL=aOutR=0.
- Write accept:
  - Triggers on the first clock where (nCE|nWE)==0 after a clock where it was 1, and only if ready=1.
  - ready then drops on the next clock and stays low for READY_CYCLES clocks.
  - Strobes arriving while ready=0 are ignored.
  - A stereo write uses the same edge rule with nStereoCE, loads stereo<=d, and does not affect ready.
  - Simultaneous PSG and stereo strobes: both are accepted.
- Byte decode:
  - Latch byte d[7]=1: ch=d[6:5], type=d[4] (1=attenuation).
    - Attenuation: att[ch]<=d[3:0].
    - Tone: freq[ch][3:0]<=d[3:0].
    - Noise tone (ch=3, type=0): noiseCtl<=d[2:0] and lfsr is reseeded.
  - Data byte d[7]=0: uses the latched ch/type.
    - Tone: freq[ch][9:4]<=d[5:0].
    - Attenuation: att[ch]<=d[3:0].
    - Noise control: noiseCtl<=d[2:0] with reseed.
  - Writes to tone channel indices >= NUM_TONES are discarded.
  - Register updates are visible one clock after accept.
- Tick: clock enable pulses high 1 clock in CLK_DIV; all generators advance only on tick.
- Tone channel:
  - 10-bit down counter; on tick, if cnt<=1, then cnt<=freq and out toggles; else cnt-1.
  - freq 0 or 1 forces out=1 constant (PCM mode).
  - A new freq takes effect at the next reload.
- Noise channel:
  - noiseCtl[1:0] selects the reload value: 00→16, 01→32, 10→64, 11→freq of tone channel NUM_TONES-1.
  - The noise counter toggles a half-rate flip on each reload; the LFSR shifts right on each 0→1 flip transition.
  - Feedback into the MSB: white (noiseCtl[2]=1) = lfsr[0]^lfsr[NOISE_TAP]; periodic = lfsr[0].
  - Noise out = lfsr[0].
  - Reseed: the LFSR reseeds on the clock after an accepted write; a tick in the same clock is overridden by the reseed.
- Attenuation table (2 dB steps), att 0..15: 8191, 6506, 5168, 4105, 3261, 2590, 2057, 1634, 1298, 1031, 819, 650, 517, 410, 326, 0.
- Channel contribution = table[att] when the channel out bit=1, else 0.
- Mix:
  - aOutL = sum over ch of contribution & stereo[4+ch].
  - aOutR = sum over ch of contribution & stereo[ch].
  - Maximum 4×8191=32764, zero-extended to OUT_WIDTH; no saturation is needed.
  - Registered: outputs change 1 clock after a tone/noise out bit or att change.
- Reset mid-write or mid-busy returns to the reset state immediately; the pending write is lost.

Test Plan:
1. Reset, then write 8'h9F, 8'hBF, 8'hDF, 8'hFF → all att=15, aOutL=aOutR=0 permanently. Each write drops ready for 32 clocks; a second strobe at busy clock 10 has no effect.
2. Write 8'h8E, 8'h0F, 8'h90 (ch0 freq=0x0FE, att 0) → aOutL toggles 0↔8191 with half-period 254×16 clocks.
3. Write ch1 freq=1, att=4 → aOutL=aOutR=3261 constant (PCM mode).
4. Noise: write 8'hE4 (white, rate 00), 8'hF0 → lfsr starts 0x8000 and shifts every 2×16×16=512 clocks. The first 16 out bits match the reference model with taps 0,3, and writing 8'hE4 again reseeds to 0x8000.
5. Stereo: ch0 and ch2 at att 0 with out=1, stereo write 8'h41 → aOutL=8191 (ch2 only), aOutR=8191 (ch0 only). Then write 8'h00 → both outputs 0 one clock later.
6. Assert reset while ready=0 and tones running → next clock ready=1, outputs 0, stereo=8'hFF.
